// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with a registered one-hot grant and a hold limit
// that forces rotation only when some other requester is waiting.
module rr_arbiter4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid
);

    localparam int HW = $clog2(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [3:0]    gnt_d;
    logic [1:0]    idx_d;
    logic          vld_d;
    logic [3:0]    others;
    logic          rel_now;

    // First set bit of r, searching upward from p+1 and wrapping; p itself is checked last.
    function automatic logic [1:0] pick_next(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] win;
        logic [1:0] cand;
        logic       found;
        win   = p;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cand = p + 2'(i);
            if (!found && r[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    function automatic logic [HW-1:0] sat_inc(input logic [HW-1:0] cnt);
        return (cnt == HOLD_MAX) ? cnt : cnt + 1'b1;
    endfunction

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        gnt_d   = gnt;
        idx_d   = gnt_idx;
        vld_d   = gnt_valid;
        others  = req & ~gnt;
        rel_now = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    idx_d   = pick_next(req, ptr_q);
                    ptr_d   = idx_d;
                    gnt_d   = onehot(idx_d);
                    vld_d   = 1'b1;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                // A lone holder is never preempted, however long the counter has saturated.
                rel_now = !req[gnt_idx] || ((hold_q == HOLD_MAX) && (|others));
                if (rel_now && (|others)) begin
                    idx_d  = pick_next(others, ptr_q);
                    ptr_d  = idx_d;
                    gnt_d  = onehot(idx_d);
                    hold_d = '0;
                end else if (rel_now) begin
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                    idx_d   = 2'b00;
                    vld_d   = 1'b0;
                    hold_d  = '0;
                end else begin
                    hold_d = sat_inc(hold_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd3;
            hold_q    <= '0;
            gnt       <= 4'b0000;
            gnt_idx   <= 2'b00;
            gnt_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            gnt       <= gnt_d;
            gnt_idx   <= idx_d;
            gnt_valid <= vld_d;
        end
    end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: a cycle-level reference model checked every
// falling edge, plus hand-computed expectations for the key scenarios.
module tb_rr_arbiter4;

    localparam int MAXH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b1111;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;

    int vectors = 0;
    int errors  = 0;

    // Reference model: who holds the grant and for how many cycles so far.
    bit active = 1'b0;
    int holder = 3;
    int held   = 0;

    // Hand-computed expectation for the cycle currently being checked.
    bit         pin_en  = 1'b0;
    logic [3:0] pin_gnt = 4'b0000;
    logic [1:0] pin_idx = 2'b00;
    logic       pin_vld = 1'b0;
    string      pin_name = "";

    rr_arbiter4 #(.MAX_HOLD(MAXH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always #5 clk = ~clk;

    function automatic int search(input logic [3:0] r, input int from);
        int j;
        for (int k = 0; k < 4; k++) begin
            j = (from + k) % 4;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [3:0] bit_of(input int i);
        return 4'b0001 << i;
    endfunction

    initial begin
        logic [3:0] rest;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                active = 1'b0;
                holder = 3;
                held   = 0;
            end else if (!active) begin
                if (req != 4'b0000) begin
                    holder = search(req, (holder + 1) % 4);
                    active = 1'b1;
                    held   = 1;
                end
            end else begin
                rest = req & ~bit_of(holder);
                if (!req[holder] || (held >= MAXH && rest != 4'b0000)) begin
                    if (rest != 4'b0000) begin
                        holder = search(rest, (holder + 1) % 4);
                        held   = 1;
                    end else begin
                        active = 1'b0;
                    end
                end else begin
                    held = held + 1;
                end
            end
        end
    end

    initial begin
        logic [3:0] eg;
        logic [1:0] ei;
        logic       ev;
        forever begin
            @(negedge clk);
            eg = active ? bit_of(holder) : 4'b0000;
            ei = active ? 2'(holder) : 2'b00;
            ev = active;
            vectors++;
            if (gnt !== eg || gnt_idx !== ei || gnt_valid !== ev) begin
                errors++;
                $display("FAIL model t=%0t: gnt=%b idx=%0d vld=%b, required gnt=%b idx=%0d vld=%b",
                         $time, gnt, gnt_idx, gnt_valid, eg, ei, ev);
            end
            if (pin_en) begin
                vectors++;
                if (gnt !== pin_gnt || gnt_idx !== pin_idx || gnt_valid !== pin_vld) begin
                    errors++;
                    $display("FAIL %s t=%0t: gnt=%b idx=%0d vld=%b, required gnt=%b idx=%0d vld=%b",
                             pin_name, $time, gnt, gnt_idx, gnt_valid, pin_gnt, pin_idx, pin_vld);
                end
            end
        end
    end

    // Apply req for one rising edge; the following falling edge checks the result.
    task automatic step(input logic [3:0] r, input bit pe, input logic [3:0] g,
                        input logic [1:0] i, input logic v, input string nm);
        req      = r;
        pin_en   = pe;
        pin_gnt  = g;
        pin_idx  = i;
        pin_vld  = v;
        pin_name = nm;
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] ri;

        step(4'b1111, 1, 4'b0000, 2'd0, 1'b0, "reset_hold_a");
        step(4'b1111, 1, 4'b0000, 2'd0, 1'b0, "reset_hold_b");
        rst = 1'b0;
        step(4'b1111, 1, 4'b0001, 2'd0, 1'b1, "first_after_reset");
        step(4'b0000, 1, 4'b0000, 2'd0, 1'b0, "drop_to_idle");

        step(4'b0100, 1, 4'b0100, 2'd2, 1'b1, "single_grant");
        step(4'b0000, 1, 4'b0000, 2'd0, 1'b0, "single_release");

        rst = 1'b1;
        step(4'b0000, 1, 4'b0000, 2'd0, 1'b0, "reset_again");
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            ri = 2'((k / 4) % 4);
            step(4'b1111, 1, 4'b0001 << ri, ri, 1'b1, "rotation");
        end
        step(4'b0000, 1, 4'b0000, 2'd0, 1'b0, "rotation_end");

        step(4'b0100, 1, 4'b0100, 2'd2, 1'b1, "wrap_take2");
        step(4'b0111, 1, 4'b0100, 2'd2, 1'b1, "wrap_keep2");
        step(4'b0011, 1, 4'b0001, 2'd0, 1'b1, "wrap_to0");
        step(4'b0000, 1, 4'b0000, 2'd0, 1'b0, "wrap_idle");

        for (int k = 0; k < 10; k++)
            step(4'b1000, 1, 4'b1000, 2'd3, 1'b1, "lone_holder");
        step(4'b1001, 1, 4'b0001, 2'd0, 1'b1, "lone_preempt");
        step(4'b0000, 1, 4'b0000, 2'd0, 1'b0, "lone_idle");

        step(4'b0010, 1, 4'b0010, 2'd1, 1'b1, "pre_async");
        @(posedge clk);
        #1;
        rst      = 1'b1;
        pin_en   = 1'b1;
        pin_gnt  = 4'b0000;
        pin_idx  = 2'd0;
        pin_vld  = 1'b0;
        pin_name = "async_clear";
        @(negedge clk);
        #1;
        rst = 1'b0;
        step(4'b1111, 1, 4'b0001, 2'd0, 1'b1, "post_async_ptr3");

        step(4'b0101, 1, 4'b0001, 2'd0, 1'b1, "others_toggle_a");
        step(4'b0001, 1, 4'b0001, 2'd0, 1'b1, "others_toggle_b");
        step(4'b0011, 1, 4'b0001, 2'd0, 1'b1, "others_toggle_c");
        step(4'b1001, 1, 4'b1000, 2'd3, 1'b1, "hold_limit_move");
        step(4'b0000, 1, 4'b0000, 2'd0, 1'b0, "final_idle");

        pin_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
